// File: rtl/lenet_infer_seq_pkg.sv
// lenet_infer_seq_pkg: shared state encodings, default word counts and size helper.
package lenet_infer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_W   = 3'd1,
        ST_LOAD_B   = 3'd2,
        ST_STREAM   = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_ERR      = 3'd5
    } seq_state_e;

    localparam int DEF_W_WORDS    = 3220;
    localparam int DEF_B_WORDS    = 10;
    localparam int DEF_FMAP_WORDS = 1024;

    // Convolution kernel words plus the flattened FC input words per output channel.
    function automatic int calc_w_words(input int ci, input int co, input int k_size, input int i_size3);
        return ci * co * k_size * k_size + co * i_size3 * i_size3;
    endfunction

endpackage

// File: rtl/lenet_infer_seq_word_counter.sv
// seq_word_counter: up-counter that wraps to 0 and flags the increment that reaches limit.
module seq_word_counter #(
    parameter int CNT_BW = 12
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic [CNT_BW-1:0] limit,
    output logic [CNT_BW-1:0] cnt,
    output logic              done
);

    assign done = inc && (cnt == limit - CNT_BW'(1));

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)
            cnt <= '0;
        else if (clr || done)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CNT_BW'(1);
    end

endmodule

// File: rtl/lenet_infer_seq.sv
// lenet_infer_seq: splits one word stream into weight/bias/fmap writes for the LeNet core and captures results.
// Optional LENET_SEQ_PERF_EN adds o_lat_cycles (first fmap accept to i_cls_end, saturating).
module lenet_infer_seq
    import lenet_infer_seq_pkg::*;
#(
    parameter int D_BW       = 8,
    parameter int W_WORDS    = DEF_W_WORDS,
    parameter int B_WORDS    = DEF_B_WORDS,
    parameter int FMAP_WORDS = DEF_FMAP_WORDS,
    parameter int CLS_BW     = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              user_reset,
    input  logic              i_start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [D_BW-1:0]   s_data,
    output logic [D_BW-1:0]   o_data,
    output logic              o_weight_we,
    output logic              o_bias_we,
    output logic              o_fmap_we,
    output logic              o_core_ce,
    input  logic [CLS_BW-1:0] i_cls_result,
    input  logic              i_cls_en,
    input  logic              i_cls_end,
    output logic [CLS_BW-1:0] o_result,
    output logic              o_result_valid,
    output logic [15:0]       o_img_cnt,
    output logic [2:0]        o_state,
    output logic              o_error
`ifdef LENET_SEQ_PERF_EN
    ,output logic [31:0]      o_lat_cycles
`endif
);

    // Sized for the largest of the three phases so any parameter mix fits.
    localparam int MAX_WORDS = (W_WORDS > B_WORDS)
        ? ((W_WORDS > FMAP_WORDS) ? W_WORDS : FMAP_WORDS)
        : ((B_WORDS > FMAP_WORDS) ? B_WORDS : FMAP_WORDS);
    localparam int CNT_BW = $clog2(MAX_WORDS + 1);
    localparam int TO_BW  = $clog2(TIMEOUT + 1);

    seq_state_e state_q, state_d;
    logic [CNT_BW-1:0] word_cnt, word_limit;
    logic [TO_BW-1:0]  to_cnt;
    logic [CLS_BW-1:0] lat_res;
    logic word_done, to_done, accept, res_evt;

    assign s_ready   = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B) || (state_q == ST_STREAM);
    assign o_core_ce = (state_q == ST_STREAM) || (state_q == ST_WAIT_RES);
    assign o_error   = (state_q == ST_ERR);
    assign o_state   = state_q;
    assign accept    = s_valid && s_ready;
    assign res_evt   = (state_q == ST_WAIT_RES) && i_cls_end;

    always_comb
        word_limit = (state_q == ST_LOAD_W) ? CNT_BW'(W_WORDS)
                   : (state_q == ST_LOAD_B) ? CNT_BW'(B_WORDS) : CNT_BW'(FMAP_WORDS);

    seq_word_counter #(.CNT_BW(CNT_BW)) u_word_cnt (
        .clk(clk), .global_rst_n(global_rst_n), .clr(user_reset), .inc(accept),
        .limit(word_limit), .cnt(word_cnt), .done(word_done)
    );

    seq_word_counter #(.CNT_BW(TO_BW)) u_timeout_cnt (
        .clk(clk), .global_rst_n(global_rst_n),
        .clr(user_reset || (state_q != ST_WAIT_RES) || i_cls_end),
        .inc(state_q == ST_WAIT_RES), .limit(TO_BW'(TIMEOUT)), .cnt(to_cnt), .done(to_done)
    );

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)
            state_q <= ST_IDLE;
        else if (user_reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = i_start ? ST_LOAD_W : ST_IDLE;
            ST_LOAD_W:   state_d = word_done ? ST_LOAD_B : ST_LOAD_W;
            ST_LOAD_B:   state_d = word_done ? ST_STREAM : ST_LOAD_B;
            ST_STREAM:   state_d = word_done ? ST_WAIT_RES : ST_STREAM;
            ST_WAIT_RES: state_d = i_cls_end ? ST_STREAM : (to_done ? ST_ERR : ST_WAIT_RES);
            ST_ERR:      state_d = ST_ERR;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            o_data         <= '0;
            o_weight_we    <= 1'b0;
            o_bias_we      <= 1'b0;
            o_fmap_we      <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_img_cnt      <= '0;
            lat_res        <= '0;
        end else if (user_reset) begin
            o_data         <= '0;
            o_weight_we    <= 1'b0;
            o_bias_we      <= 1'b0;
            o_fmap_we      <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_img_cnt      <= '0;
            lat_res        <= '0;
        end else begin
            o_data         <= accept ? s_data : o_data;
            o_weight_we    <= accept && (state_q == ST_LOAD_W);
            o_bias_we      <= accept && (state_q == ST_LOAD_B);
            o_fmap_we      <= accept && (state_q == ST_STREAM);
            o_result_valid <= res_evt;
            if ((state_q == ST_WAIT_RES) && i_cls_en)
                lat_res <= i_cls_result;
            // A result arriving with the end marker takes priority over the latched one.
            if (res_evt) begin
                o_result  <= i_cls_en ? i_cls_result : lat_res;
                o_img_cnt <= o_img_cnt + 16'd1;
            end
        end
    end

`ifdef LENET_SEQ_PERF_EN
    logic        lat_run;
    logic [31:0] lat_cnt;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            lat_run      <= 1'b0;
            lat_cnt      <= '0;
            o_lat_cycles <= '0;
        end else if (user_reset) begin
            lat_run      <= 1'b0;
            lat_cnt      <= '0;
            o_lat_cycles <= '0;
        end else if (res_evt) begin
            lat_run      <= 1'b0;
            lat_cnt      <= '0;
            o_lat_cycles <= lat_cnt;
        end else if (accept && (state_q == ST_STREAM) && !lat_run) begin
            lat_run <= 1'b1;
            lat_cnt <= 32'd1;
        end else if (lat_run && (lat_cnt != '1)) begin
            lat_cnt <= lat_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lenet_infer_seq.sv
// tb_lenet_infer_seq: scoreboard bench; stimulus pushes expected strobes/results, a negedge monitor pops and compares.
module tb_lenet_infer_seq;

    localparam logic [2:0] KW = 3'b001, KB = 3'b010, KF = 3'b100;

    logic        clk = 1'b0;
    logic        global_rst_n = 1'b0;
    logic        user_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic [7:0]  o_data;
    logic        o_weight_we, o_bias_we, o_fmap_we, o_core_ce;
    logic [3:0]  i_cls_result = '0;
    logic        i_cls_en = 1'b0;
    logic        i_cls_end = 1'b0;
    logic [3:0]  o_result;
    logic        o_result_valid;
    logic [15:0] o_img_cnt;
    logic [2:0]  o_state;
    logic        o_error;

    int n_cmp = 0;
    int n_bad = 0;
    int w_seen = 0;
    logic [10:0] sq[$];
    logic [19:0] rq[$];
    logic [10:0] se;
    logic [19:0] re;

    lenet_infer_seq #(
        .D_BW(8), .W_WORDS(4), .B_WORDS(2), .FMAP_WORDS(3), .CLS_BW(4), .TIMEOUT(20)
    ) dut (
        .clk(clk), .global_rst_n(global_rst_n), .user_reset(user_reset), .i_start(i_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .o_data(o_data),
        .o_weight_we(o_weight_we), .o_bias_we(o_bias_we), .o_fmap_we(o_fmap_we),
        .o_core_ce(o_core_ce), .i_cls_result(i_cls_result), .i_cls_en(i_cls_en),
        .i_cls_end(i_cls_end), .o_result(o_result), .o_result_valid(o_result_valid),
        .o_img_cnt(o_img_cnt), .o_state(o_state), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, s_ready, o_data, o_weight_we, o_bias_we, o_fmap_we, o_core_ce,
                o_result, o_result_valid, o_img_cnt, o_state, o_error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for s_ready, then offers one word for exactly one accepting edge.
    task automatic send(input logic [7:0] d, input logic [2:0] kind, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data = d;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            chk("send_ready_timeout", 0, 1);
        end else begin
            sq.push_back({kind, d});
            tick();
        end
        s_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (global_rst_n && (o_weight_we || o_bias_we || o_fmap_we)) begin
            if (o_weight_we) w_seen++;
            if (sq.size() == 0) begin
                chk("unexpected_strobe", {o_fmap_we, o_bias_we, o_weight_we, o_data}, 0);
            end else begin
                se = sq.pop_front();
                chk("strobe_data", {o_fmap_we, o_bias_we, o_weight_we, o_data}, se);
            end
        end
        if (global_rst_n && o_result_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_result", {o_result, o_img_cnt}, 0);
            end else begin
                re = rq.pop_front();
                chk("result_imgcnt", {o_result, o_img_cnt}, re);
            end
        end
    end

    initial begin
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 0);
        global_rst_n = 1'b1;
        tick();
        chk("idle_after_reset", all_outs(), 0);

        // Full load: 4 weights, 2 biases, 3 fmap words back to back.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("state_load_w", o_state, 1);
        for (int i = 1; i <= 9; i++) begin
            send(8'(i), (i <= 4) ? KW : (i <= 6) ? KB : KF, 0);
            if (i == 5) chk("ce_off_in_load_b", o_core_ce, 0);
            if (i == 6) chk("ce_on_after_bias", o_core_ce, 1);
        end
        chk("state_wait_res", o_state, 4);
        chk("sready_wait_res", s_ready, 0);
        chk("ce_wait_res", o_core_ce, 1);

        // Latched result, end marker two cycles later.
        i_cls_en = 1'b1;
        i_cls_result = 4'd7;
        tick();
        i_cls_en = 1'b0;
        i_cls_result = 4'd9;
        tick();
        i_cls_end = 1'b1;
        rq.push_back({4'd7, 16'd1});
        tick();
        i_cls_end = 1'b0;
        chk("res_valid_pulse", o_result_valid, 1);
        chk("state_back_stream", o_state, 3);
        tick();
        chk("res_valid_one_cycle", o_result_valid, 0);
        chk("result_hold", o_result, 7);

        // End marker outside WAIT_RES must be ignored.
        i_cls_end = 1'b1;
        tick();
        i_cls_end = 1'b0;
        tick();
        chk("cls_end_ignored_cnt", o_img_cnt, 1);

        // Second image, result arriving with the end marker.
        for (int i = 10; i <= 12; i++) send(8'(i), KF, 0);
        chk("state_wait_res2", o_state, 4);
        i_cls_end = 1'b1;
        i_cls_en = 1'b1;
        i_cls_result = 4'd3;
        rq.push_back({4'd3, 16'd2});
        tick();
        i_cls_end = 1'b0;
        i_cls_en = 1'b0;
        chk("state_stream2", o_state, 3);
        chk("result2", o_result, 3);

        // Timeout: 20 cycles in WAIT_RES without an end marker.
        for (int i = 13; i <= 15; i++) send(8'(i), KF, 0);
        repeat (19) tick();
        chk("no_timeout_yet", o_state, 4);
        tick();
        chk("state_err", o_state, 5);
        chk("error_flag", o_error, 1);
        chk("sready_err", s_ready, 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("err_sticky", o_state, 5);
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        chk("user_reset_outputs", all_outs(), 0);

        // Weight load with valid gaps and a stray i_start.
        w_seen = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        send(8'hA1, KW, 2);
        send(8'hA2, KW, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_ignored", o_state, 1);
        send(8'hA3, KW, 3);
        send(8'hA4, KW, 1);
        tick();
        chk("weight_strobe_count", w_seen, 4);
        chk("state_load_b_after_gaps", o_state, 2);

        // Async reset in the middle of a weight load.
        global_rst_n = 1'b0;
        tick();
        global_rst_n = 1'b1;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        send(8'hB1, KW, 0);
        send(8'hB2, KW, 0);
        @(negedge clk);
        #2;
        global_rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        tick();
        global_rst_n = 1'b1;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), KW, 0);
        chk("weight_count_restart", o_state, 2);
        send(8'hD0, KB, 0);
        send(8'hD1, KB, 0);
        for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), KF, 0);
        i_cls_end = 1'b1;
        i_cls_en = 1'b1;
        i_cls_result = 4'd5;
        rq.push_back({4'd5, 16'd1});
        tick();
        i_cls_end = 1'b0;
        i_cls_en = 1'b0;
        repeat (3) tick();
        chk("strobe_queue_drained", sq.size(), 0);
        chk("result_queue_drained", rq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
